// File: rtl/avst_credit_pkg.sv
// Shared types for the credit-based Avalon-ST bridge: stream beat layout,
// bridge FSM states and a small pool-size helper.
package avst_credit_pkg;

    // Field widths of the stored stream beat. Instances of credit_to_ready
    // keep their data/empty/channel parameters equal to these values.
    localparam int DATA_W    = 128;
    localparam int EMPTY_W   = 4;
    localparam int CHANNEL_W = 10;

    typedef struct packed {
        logic [CHANNEL_W-1:0] channel;
        logic [DATA_W-1:0]    data;
        logic                 valid;
        logic                 sop;
        logic                 eop;
        logic [EMPTY_W-1:0]   empty;
    } avst_beat_t;

    typedef enum logic {
        WAIT_INIT = 1'b0,
        ACTIVE    = 1'b1
    } credit_state_t;

    // Largest number of credits the receiver may hand out at once.
    function automatic int pool_max(input int credit_width);
        return 1 << credit_width;
    endfunction

endpackage

// File: rtl/credit_counter.sv
// Available-credit pool: adds granted credits, removes one per transfer and
// one per returned credit, saturates at the pool size and flags overflow.
module credit_counter
    import avst_credit_pkg::*;
#(
    parameter int credit_width = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  add,
    input  logic [credit_width-1:0] add_val,
    input  logic                  dec_tx,
    input  logic                  dec_ret,
    output logic [credit_width:0] cnt,
    output logic                  nonzero,
    output logic                  overflow
);

    localparam int SUM_W = credit_width + 2;
    localparam logic [credit_width:0] POOL_CNT = (credit_width+1)'(pool_max(credit_width));

    logic [credit_width:0] r_cnt;
    logic                  r_overflow;
    logic [SUM_W-1:0]      w_sum;
    logic [credit_width:0] w_next;
    logic                  w_over;

    // Next pool value; decrements only arrive while the pool is non-empty and
    // never both in one cycle, so the sum cannot go below zero.
    always_comb begin
        w_sum  = SUM_W'(r_cnt) + (add ? SUM_W'(add_val) : '0)
               - SUM_W'(dec_tx) - SUM_W'(dec_ret);
        w_over = (w_sum > SUM_W'(POOL_CNT));
        w_next = w_over ? POOL_CNT : w_sum[credit_width:0];
    end

    // Pool register and sticky overflow flag.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!reset_n) begin
            r_cnt      <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_cnt <= w_next;
            if (w_over) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign cnt      = r_cnt;
    assign nonzero  = (r_cnt != '0);
    assign overflow = r_overflow;

endmodule

// File: rtl/credit_to_ready.sv
// Bridge from a ready-based Avalon-ST sink to a credit-based source: beats are
// accepted only while credits are available and forwarded one cycle later;
// credits left unused during long idle stretches are handed back one by one.
module credit_to_ready
    import avst_credit_pkg::*;
#(
    parameter int data_width    = 128,
    parameter int empty_width   = 4,
    parameter int channel_width = 10,
    parameter int credit_width  = 5,
    parameter int idle_return   = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [channel_width-1:0] avsi_channel,
    input  logic [data_width-1:0]    avsi_data,
    input  logic                     avsi_sop,
    input  logic                     avsi_eop,
    input  logic [empty_width-1:0]   avsi_empty,
    input  logic                     avsi_valid,
    output logic                     avsi_ready,
    input  logic                     update_credit,
    input  logic [credit_width-1:0]  credit,
    output logic                     return_credit,
    output logic [channel_width-1:0] avso_channel,
    output logic [data_width-1:0]    avso_data,
    output logic                     avso_valid,
    output logic                     avso_sop,
    output logic                     avso_eop,
    output logic [empty_width-1:0]   avso_empty,
    output logic                     credit_overflow
);

    localparam int IDLE_W = $clog2(idle_return + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(idle_return - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(idle_return);

    credit_state_t         r_state;
    credit_state_t         w_state_next;
    logic [IDLE_W-1:0]     r_idle;
    logic [IDLE_W-1:0]     w_idle_next;
    avst_beat_t            r_beat;
    logic [credit_width:0] w_cnt;
    logic                  w_nonzero;
    logic                  w_overflow;
    logic                  w_ready;
    logic                  w_xfer;
    logic                  w_return;
    logic                  w_grant;

    assign w_grant  = update_credit && (credit != '0);
    assign w_xfer   = avsi_valid && w_ready;
    assign w_return = (r_idle == IDLE_LAST) && (w_cnt != '0) && !w_xfer;

    credit_counter #(
        .credit_width (credit_width)
    ) u_credit_counter (
        .clk      (clk),
        .reset_n  (reset_n),
        .add      (update_credit),
        .add_val  (credit),
        .dec_tx   (w_xfer),
        .dec_ret  (w_return),
        .cnt      (w_cnt),
        .nonzero  (w_nonzero),
        .overflow (w_overflow)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= WAIT_INIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state and ready decode; ready depends on registers only.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path through the case statement can leave a latch behind.
        w_state_next = r_state;
        w_ready      = 1'b0;
        case (r_state)
            WAIT_INIT: begin
                if (w_grant) begin
                    w_state_next = ACTIVE;
                end
            end
            ACTIVE: begin
                w_ready = w_nonzero;
            end
            default: begin
                w_state_next = WAIT_INIT;
            end
        endcase
    end

    // Idle counter: cleared by sink activity or a return, otherwise counts up
    // and parks at idle_return.
    always_comb begin
        w_idle_next = r_idle;
        if (avsi_valid || w_xfer || w_return) begin
            w_idle_next = '0;
        end else if (r_idle != IDLE_MAX) begin
            w_idle_next = r_idle + 1'b1;
        end
    end

    // Idle counter register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_idle <= '0;
        end else begin
            r_idle <= w_idle_next;
        end
    end

    // Output beat register: captures the accepted beat, valid for one cycle.
    always_ff @(posedge clk) begin
        // NOTE: the wide payload is reset as well, since the source side must
        // read all-zero fields after reset and a stale beat must not survive.
        if (!reset_n) begin
            r_beat <= '0;
        end else begin
            r_beat.valid <= w_xfer;
            if (w_xfer) begin
                r_beat.channel <= avsi_channel;
                r_beat.data    <= avsi_data;
                r_beat.sop     <= avsi_sop;
                r_beat.eop     <= avsi_eop;
                r_beat.empty   <= avsi_eop ? avsi_empty : '0;
            end
        end
    end

    assign avsi_ready      = w_ready;
    assign return_credit   = w_return;
    assign credit_overflow = w_overflow;
    assign avso_channel    = r_beat.channel;
    assign avso_data       = r_beat.data;
    assign avso_valid      = r_beat.valid;
    assign avso_sop        = r_beat.sop;
    assign avso_eop        = r_beat.eop;
    assign avso_empty      = r_beat.empty;

endmodule

// File: tb/tb_credit_to_ready.sv
// Bench for credit_to_ready: directed vector table, hand-written multi-cycle
// sequences and randomized traffic, all compared against a behavioural model.
module tb_credit_to_ready;

    localparam int DW   = 128;
    localparam int EW   = 4;
    localparam int CHW  = 10;
    localparam int CW   = 5;
    localparam int IR   = 16;
    localparam int POOL = 1 << CW;

    logic           clk;
    logic           reset_n;
    logic [CHW-1:0] avsi_channel;
    logic [DW-1:0]  avsi_data;
    logic           avsi_sop;
    logic           avsi_eop;
    logic [EW-1:0]  avsi_empty;
    logic           avsi_valid;
    logic           avsi_ready;
    logic           update_credit;
    logic [CW-1:0]  credit;
    logic           return_credit;
    logic [CHW-1:0] avso_channel;
    logic [DW-1:0]  avso_data;
    logic           avso_valid;
    logic           avso_sop;
    logic           avso_eop;
    logic [EW-1:0]  avso_empty;
    logic           credit_overflow;

    credit_to_ready #(
        .data_width    (DW),
        .empty_width   (EW),
        .channel_width (CHW),
        .credit_width  (CW),
        .idle_return   (IR)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .avsi_channel    (avsi_channel),
        .avsi_data       (avsi_data),
        .avsi_sop        (avsi_sop),
        .avsi_eop        (avsi_eop),
        .avsi_empty      (avsi_empty),
        .avsi_valid      (avsi_valid),
        .avsi_ready      (avsi_ready),
        .update_credit   (update_credit),
        .credit          (credit),
        .return_credit   (return_credit),
        .avso_channel    (avso_channel),
        .avso_data       (avso_data),
        .avso_valid      (avso_valid),
        .avso_sop        (avso_sop),
        .avso_eop        (avso_eop),
        .avso_empty      (avso_empty),
        .credit_overflow (credit_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: credit pool, initialised flag, idle run length and
    // the beat expected on the source side in the following cycle.
    bit             m_init;
    int             m_cnt;
    int             m_idle;
    bit             m_ovf;
    bit             m_ov;
    logic [DW-1:0]  m_data;
    logic [CHW-1:0] m_channel;
    bit             m_sop;
    bit             m_eop;
    logic [EW-1:0]  m_empty;

    task automatic model_reset();
        m_init = 0; m_cnt = 0; m_idle = 0; m_ovf = 0; m_ov = 0;
        m_data = '0; m_channel = '0; m_sop = 0; m_eop = 0; m_empty = '0;
    endtask

    // One clock cycle: drive inputs just after the rising edge, compare at the
    // falling edge, advance the model, then cross the next rising edge.
    task automatic cycle(input bit rst_n_i, input bit valid, input bit sop, input bit eop,
                         input bit upd, input logic [CW-1:0] cr,
                         output bit s_ready, output bit s_ret, output bit s_ov, output bit s_ovf);
        bit exp_ready, xfer, exp_ret;
        int nxt;
        reset_n       = rst_n_i;
        avsi_valid    = valid;
        avsi_sop      = sop;
        avsi_eop      = eop;
        avsi_data     = {$urandom, $urandom, $urandom, $urandom};
        avsi_channel  = CHW'($urandom);
        avsi_empty    = EW'($urandom);
        update_credit = upd;
        credit        = cr;
        #4;
        exp_ready = m_init && (m_cnt > 0);
        xfer      = valid && exp_ready;
        exp_ret   = (m_idle == IR - 1) && (m_cnt > 0) && !xfer;
        check("avsi_ready", avsi_ready, exp_ready);
        check("return_credit", return_credit, exp_ret);
        check("avso_valid", avso_valid, m_ov);
        check("credit_overflow", credit_overflow, m_ovf);
        if (m_ov) begin
            check("avso_data", avso_data, m_data);
            check("avso_channel", avso_channel, m_channel);
            check("avso_sop", avso_sop, m_sop);
            check("avso_eop", avso_eop, m_eop);
            check("avso_empty", avso_empty, m_empty);
        end
        s_ready = avsi_ready;
        s_ret   = return_credit;
        s_ov    = avso_valid;
        s_ovf   = credit_overflow;
        if (!rst_n_i) begin
            model_reset();
        end else begin
            nxt = m_cnt + (upd ? int'(cr) : 0) - (xfer ? 1 : 0) - (exp_ret ? 1 : 0);
            if (nxt > POOL) begin
                nxt   = POOL;
                m_ovf = 1;
            end
            m_cnt = nxt;
            if (upd && cr != 0) m_init = 1;
            if (valid || xfer || exp_ret) m_idle = 0;
            else if (m_idle < IR) m_idle++;
            m_ov = xfer;
            if (xfer) begin
                m_data    = avsi_data;
                m_channel = avsi_channel;
                m_sop     = sop;
                m_eop     = eop;
                m_empty   = eop ? avsi_empty : '0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int rst_n, valid, sop, eop, upd, cr;
        int e_ready, e_ret, e_ov, e_ovf;
    } vec_t;

    vec_t vecs[18];

    initial begin
        bit r, rt, ov, of;
        int accepted, n_ret, first_ret, second_ret, vpct;

        vecs[0]  = '{1, 0, 0, 0, 1, 31, 0, 0, 0, 0};
        vecs[1]  = '{1, 0, 0, 0, 0,  0, 1, 0, 0, 0};
        vecs[2]  = '{0, 0, 0, 0, 0,  0, 1, 0, 0, 0};
        vecs[3]  = '{1, 0, 0, 0, 1,  3, 0, 0, 0, 0};
        vecs[4]  = '{1, 1, 1, 0, 0,  0, 1, 0, 0, 0};
        vecs[5]  = '{1, 1, 0, 0, 0,  0, 1, 0, 1, 0};
        vecs[6]  = '{1, 1, 0, 0, 0,  0, 1, 0, 1, 0};
        vecs[7]  = '{1, 1, 0, 0, 0,  0, 0, 0, 1, 0};
        vecs[8]  = '{1, 1, 0, 1, 0,  0, 0, 0, 0, 0};
        vecs[9]  = '{1, 0, 0, 0, 0,  0, 0, 0, 0, 0};
        vecs[10] = '{1, 0, 0, 0, 1,  1, 0, 0, 0, 0};
        vecs[11] = '{1, 1, 1, 1, 1,  2, 1, 0, 0, 0};
        vecs[12] = '{1, 0, 0, 0, 0,  0, 1, 0, 1, 0};
        vecs[13] = '{1, 0, 0, 0, 0,  0, 1, 0, 0, 0};
        vecs[14] = '{1, 0, 0, 0, 1, 28, 1, 0, 0, 0};
        vecs[15] = '{1, 0, 0, 0, 1,  5, 1, 0, 0, 0};
        vecs[16] = '{1, 0, 0, 0, 0,  0, 1, 0, 0, 1};
        vecs[17] = '{1, 0, 0, 0, 0,  0, 1, 0, 0, 1};

        reset_n = 1'b0; avsi_valid = 1'b0; avsi_sop = 1'b0; avsi_eop = 1'b0;
        avsi_data = '0; avsi_channel = '0; avsi_empty = '0;
        update_credit = 1'b0; credit = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check("reset avsi_ready", avsi_ready, 1'b0);
        check("reset avso_valid", avso_valid, 1'b0);
        check("reset avso_data", avso_data, '0);

        // Directed table: init with 31, init with 3 against 5 beats, grant
        // while empty, grant+transfer same cycle, overflow to 32.
        for (int i = 0; i < 18; i++) begin
            cycle(vecs[i].rst_n != 0, vecs[i].valid != 0, vecs[i].sop != 0, vecs[i].eop != 0,
                  vecs[i].upd != 0, CW'(vecs[i].cr), r, rt, ov, of);
            check($sformatf("vec%0d ready", i), r, vecs[i].e_ready != 0);
            check($sformatf("vec%0d return", i), rt, vecs[i].e_ret != 0);
            check($sformatf("vec%0d avso_valid", i), ov, vecs[i].e_ov != 0);
            check($sformatf("vec%0d overflow", i), of, vecs[i].e_ovf != 0);
        end

        // Saturated pool must hold exactly 32 credits.
        accepted = 0;
        for (int i = 0; i < 34; i++) begin
            cycle(1, 1, 0, 0, 0, '0, r, rt, ov, of);
            if (r) accepted++;
        end
        check("saturated pool drain", accepted, POOL);
        check("overflow sticky", credit_overflow, 1'b1);

        // Idle returns: pool of 4 after one beat, 40 idle cycles.
        cycle(0, 0, 0, 0, 0, '0, r, rt, ov, of);
        cycle(1, 0, 0, 0, 1, 5'd5, r, rt, ov, of);
        cycle(1, 1, 1, 1, 0, '0, r, rt, ov, of);
        n_ret = 0; first_ret = 0; second_ret = 0;
        for (int i = 1; i <= 40; i++) begin
            cycle(1, 0, 0, 0, 0, '0, r, rt, ov, of);
            if (rt) begin
                n_ret++;
                if (n_ret == 1) first_ret = i;
                if (n_ret == 2) second_ret = i;
            end
        end
        check("idle return count", n_ret, 2);
        check("first return cycle", first_ret, 16);
        check("second return cycle", second_ret, 32);
        accepted = 0;
        for (int i = 0; i < 4; i++) begin
            cycle(1, 1, 0, 0, 0, '0, r, rt, ov, of);
            if (r) accepted++;
        end
        check("credits left after returns", accepted, 2);

        // Reset mid-packet with overflow set and a beat in flight.
        cycle(0, 0, 0, 0, 0, '0, r, rt, ov, of);
        cycle(1, 0, 0, 0, 1, 5'd31, r, rt, ov, of);
        cycle(1, 0, 0, 0, 1, 5'd31, r, rt, ov, of);
        cycle(1, 1, 1, 0, 0, '0, r, rt, ov, of);
        cycle(0, 1, 0, 0, 0, '0, r, rt, ov, of);
        check("in-flight beat before reset", ov, 1'b1);
        check("post-reset avso_valid", avso_valid, 1'b0);
        check("post-reset avso_data", avso_data, '0);
        check("post-reset avso_channel", avso_channel, '0);
        check("post-reset sop/eop/empty", {avso_sop, avso_eop, avso_empty}, '0);
        check("post-reset avsi_ready", avsi_ready, 1'b0);
        check("post-reset overflow", credit_overflow, 1'b0);
        cycle(1, 1, 0, 0, 1, '0, r, rt, ov, of);
        cycle(1, 1, 0, 0, 0, '0, r, rt, ov, of);
        check("zero grant keeps WAIT_INIT", r, 1'b0);

        // Randomized traffic with phases of differing sink activity.
        vpct = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 64 == 0) begin
                case ($urandom_range(0, 2))
                    0:       vpct = 0;
                    1:       vpct = 30;
                    default: vpct = 90;
                endcase
            end
            cycle($urandom_range(0, 299) != 0, $urandom_range(0, 99) < vpct,
                  $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0,
                  $urandom_range(0, 15) == 0, CW'($urandom), r, rt, ov, of);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
